// File: rtl/gf_mul_seq_pkg.sv
// Shared definitions for the iterative GF(2^n) lane multiplier.
// Holds the default field width, the AES reduction polynomial, the
// controller state encoding and a helper that locates a lane inside a
// packed lane vector.
package gf_mul_seq_pkg;

    // Default field degree / element width in bits.
    localparam int unsigned GF_WIDTH = 8;

    // AES polynomial x^8 + x^4 + x^3 + x + 1 with the x^8 term implied.
    localparam logic [GF_WIDTH-1:0] AES_POLY = 8'h1B;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // LSB position of lane `lane` in a vector packed as [lane*width +: width].
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/gf_mac_step.sv
// One shift-and-add step of a GF(2^WIDTH) multiply.
//   acc_in    : running product
//   m_in      : multiplicand already scaled by x^k
//   bit_in    : multiplier bit k
//   acc_out_c : acc_in ^ m_in when bit_in is set, else acc_in
//   m_out_c   : xtime(m_in), i.e. m_in * x reduced by POLY
// Purely combinational; chained to consume several multiplier bits per cycle.
module gf_mac_step
    import gf_mul_seq_pkg::*;
#(
    parameter int unsigned       WIDTH = GF_WIDTH,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'(AES_POLY)
) (
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] m_in,
    input  logic             bit_in,
    output logic [WIDTH-1:0] acc_out_c,
    output logic [WIDTH-1:0] m_out_c
);

    // Conditional accumulate plus xtime; field addition is XOR.
    always_comb begin
        acc_out_c = bit_in ? (acc_in ^ m_in) : acc_in;
        m_out_c   = {m_in[WIDTH-2:0], 1'b0} ^ (m_in[WIDTH-1] ? POLY : '0);
    end

endmodule

// File: rtl/gf_mul_seq.sv
// Iterative GF(2^WIDTH) multiplier: LANES field elements times one shared
// runtime coefficient, LSB-first, STEPS multiplier bits per RUN cycle.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : operand set offered on a / b
//   in_ready   : operand set can be accepted (IDLE, or DONE being retired)
//   a          : multiplicands, lane i at [i*WIDTH +: WIDTH]
//   b          : shared multiplier coefficient
//   out_valid  : p holds a finished result
//   out_ready  : consumer takes the result
//   p          : products a[i]*b mod poly, same packing as a
// With EARLY_EXIT the run stops once all remaining multiplier bits are
// zero. A result being retired in DONE may overlap with capture of the
// next operand set, so back-to-back operations have no bubble.
module gf_mul_seq
    import gf_mul_seq_pkg::*;
#(
    parameter int unsigned       WIDTH      = GF_WIDTH,
    parameter logic [WIDTH-1:0]  POLY       = WIDTH'(AES_POLY),
    parameter int unsigned       LANES      = 4,
    parameter int unsigned       STEPS      = 1,
    parameter bit                EARLY_EXIT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [WIDTH-1:0]       b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] p
);

    localparam int unsigned RUN_CYCLES = WIDTH / STEPS;
    localparam int unsigned CNT_W      = $clog2(RUN_CYCLES + 1);
    localparam int unsigned VEC_W      = LANES * WIDTH;

    state_t state_q, state_d;

    logic [WIDTH-1:0] m_q   [LANES];
    logic [WIDTH-1:0] m_d   [LANES];
    logic [WIDTH-1:0] acc_q [LANES];
    logic [WIDTH-1:0] acc_d [LANES];
    logic [WIDTH-1:0] m_fin   [LANES];
    logic [WIDTH-1:0] acc_fin [LANES];

    logic [WIDTH-1:0] mb_q, mb_d, mb_next;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
    logic [VEC_W-1:0] p_q, p_d, acc_pack;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             run_last;

    // Per-lane chain of STEPS mac steps; step s consumes multiplier bit s.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar s = 0; s < STEPS; s++) begin : g_step
            logic [WIDTH-1:0] acc_i;
            logic [WIDTH-1:0] m_i;
            logic [WIDTH-1:0] acc_o;
            logic [WIDTH-1:0] m_o;

            if (s == 0) begin : g_head
                assign acc_i = acc_q[l];
                assign m_i   = m_q[l];
            end else begin : g_link
                assign acc_i = g_step[s-1].acc_o;
                assign m_i   = g_step[s-1].m_o;
            end

            gf_mac_step #(
                .WIDTH (WIDTH),
                .POLY  (POLY)
            ) u_step (
                .acc_in    (acc_i),
                .m_in      (m_i),
                .bit_in    (mb_q[s]),
                .acc_out_c (acc_o),
                .m_out_c   (m_o)
            );
        end : g_step

        assign acc_fin[l] = g_step[STEPS-1].acc_o;
        assign m_fin[l]   = g_step[STEPS-1].m_o;
    end : g_lane

    // Repack the final accumulators into the output lane layout.
    always_comb begin
        acc_pack = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            acc_pack[lane_lsb(l, WIDTH) +: WIDTH] = acc_fin[l];
        end
    end

    // Post-cycle multiplier/counter values and the RUN exit condition.
    assign mb_next  = mb_q >> STEPS;
    assign cnt_next = cnt_q + CNT_W'(1);
    assign run_last = (cnt_next == CNT_W'(RUN_CYCLES)) ||
                      (EARLY_EXIT && (mb_next == '0));
    assign accept   = in_valid && in_ready;

    // Ready is held low while reset is asserted, whatever the state.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE goes straight to RUN on a back-to-back accept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (run_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = RUN;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        m_d         = m_q;
        acc_d       = acc_q;
        mb_d        = mb_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        out_valid_d = (state_d == DONE);

        if (accept) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                m_d[l]   = a[lane_lsb(l, WIDTH) +: WIDTH];
                acc_d[l] = '0;
            end
            mb_d  = b;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            m_d   = m_fin;
            acc_d = acc_fin;
            mb_d  = mb_next;
            cnt_d = cnt_next;
            // Result is captured on the edge that enters DONE.
            if (run_last) begin
                p_d = acc_pack;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                m_q[l]   <= '0;
                acc_q[l] <= '0;
            end
            mb_q        <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            m_q         <= m_d;
            acc_q       <= acc_d;
            mb_q        <= mb_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_gf_mul_seq.sv
// Directed bench for gf_mul_seq: default configuration plus STEPS=4 and
// STEPS=8 instances (no early exit) sharing the same input stream.
module tb_gf_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [7:0]  b;

    logic        in_ready,  out_valid;
    logic [31:0] p;
    logic        rdy4, ov4;
    logic [31:0] p4;
    logic        rdy8, ov8;
    logic [31:0] p8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .LANES(4), .STEPS(1), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .LANES(4), .STEPS(4), .EARLY_EXIT(1'b0)) dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .a(a), .b(b), .out_valid(ov4), .out_ready(out_ready), .p(p4)
    );

    gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .LANES(4), .STEPS(8), .EARLY_EXIT(1'b0)) dut_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .a(a), .b(b), .out_valid(ov8), .out_ready(out_ready), .p(p8)
    );

    // Drain: no new operands, consumer ready, k cycles.
    task automatic idle_cycles(input int k);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Offer one operand set to the default instance; n = cycles from accept
    // edge to out_valid (40 on timeout), pv = p when out_valid was seen.
    task automatic run_op(input logic [31:0] av, input logic [7:0] bv,
                          output int n, output logic [31:0] pv);
        int g;
        a = av; b = bv; in_valid = 1'b1; g = 0;
        while (in_ready !== 1'b1 && g < 20) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        pv = p;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov: got %b want 0", out_valid); end
        total++; if (p !== 32'h0) begin bad++; $display("FAIL reset_p: got %h want 00000000", p); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_ov: got %b want 0", out_valid); end
    endtask

    task automatic test_fips();
        int n; logic [31:0] pv;
        idle_cycles(2);
        run_op(32'h0000_0057, 8'h83, n, pv);
        total++; if (n !== 8) begin bad++; $display("FAIL fips_lat: got %0d want 8", n); end
        total++; if (pv !== 32'h0000_00C1) begin bad++; $display("FAIL fips_p: got %h want 000000c1", pv); end
    endtask

    task automatic test_column();
        int n; logic [31:0] pv;
        idle_cycles(2);
        run_op(32'h4553_13DB, 8'h02, n, pv);
        total++; if (n !== 2) begin bad++; $display("FAIL col_lat: got %0d want 2", n); end
        total++; if (pv !== 32'h8AA6_26AD) begin bad++; $display("FAIL col_p: got %h want 8aa626ad", pv); end
    endtask

    task automatic test_zero_one();
        int n; logic [31:0] pv;
        idle_cycles(2);
        run_op(32'h0000_0057, 8'h00, n, pv);
        total++; if (n !== 1) begin bad++; $display("FAIL zero_lat: got %0d want 1", n); end
        total++; if (pv !== 32'h0) begin bad++; $display("FAIL zero_p: got %h want 00000000", pv); end
        idle_cycles(2);
        run_op(32'h4553_13DB, 8'h01, n, pv);
        total++; if (n !== 1) begin bad++; $display("FAIL one_lat: got %0d want 1", n); end
        total++; if (pv !== 32'h4553_13DB) begin bad++; $display("FAIL one_p: got %h want 455313db", pv); end
    endtask

    task automatic test_back_to_back();
        int n; logic [31:0] pv;
        idle_cycles(2);
        out_ready = 1'b0;
        run_op(32'h0000_0057, 8'h13, n, pv);
        total++; if (n !== 5) begin bad++; $display("FAIL bp_lat: got %0d want 5", n); end
        total++; if (pv !== 32'h0000_00FE) begin bad++; $display("FAIL bp_p: got %h want 000000fe", pv); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_ov[%0d]: got %b want 1", i, out_valid); end
            total++; if (p !== 32'h0000_00FE) begin bad++; $display("FAIL bp_hold_p[%0d]: got %h want 000000fe", i, p); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, in_ready); end
        end
        a = 32'h0000_0057; b = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_ov: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_run_ready: got %b want 0", in_ready); end
        // Operand bus changes during RUN must not disturb the result.
        a = 32'hFFFF_FFFF; b = 8'hFF;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        total++; if (n !== 2) begin bad++; $display("FAIL b2b_lat: got %0d want 2", n); end
        total++; if (p !== 32'h0000_00F9) begin bad++; $display("FAIL b2b_p: got %h want 000000f9", p); end
    endtask

    task automatic test_steps();
        int n1, n4, n8;
        logic [31:0] pp1, pp4, pp8;
        idle_cycles(12);
        n1 = 0; n4 = 0; n8 = 0; pp1 = '0; pp4 = '0; pp8 = '0;
        a = 32'h0000_0057; b = 8'h83; in_valid = 1'b1;
        #1;
        total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL s4_ready: got %b want 1", rdy4); end
        total++; if (rdy8 !== 1'b1) begin bad++; $display("FAIL s8_ready: got %b want 1", rdy8); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 && n1 == 0) begin n1 = c; pp1 = p;  end
            if (ov4 === 1'b1 && n4 == 0)       begin n4 = c; pp4 = p4; end
            if (ov8 === 1'b1 && n8 == 0)       begin n8 = c; pp8 = p8; end
        end
        total++; if (n4 !== 2) begin bad++; $display("FAIL s4_lat: got %0d want 2", n4); end
        total++; if (pp4 !== 32'h0000_00C1) begin bad++; $display("FAIL s4_p: got %h want 000000c1", pp4); end
        total++; if (n8 !== 1) begin bad++; $display("FAIL s8_lat: got %0d want 1", n8); end
        total++; if (pp8 !== 32'h0000_00C1) begin bad++; $display("FAIL s8_p: got %h want 000000c1", pp8); end
        total++; if (n1 !== 8) begin bad++; $display("FAIL s1_lat: got %0d want 8", n1); end
        total++; if (pp1 !== 32'h0000_00C1) begin bad++; $display("FAIL s1_p: got %h want 000000c1", pp1); end
    endtask

    task automatic test_reset_mid();
        int n; logic [31:0] pv;
        idle_cycles(4);
        a = 32'h0000_0057; b = 8'h83; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_ov: got %b want 0", out_valid); end
        total++; if (p !== 32'h0) begin bad++; $display("FAIL mid_p: got %h want 00000000", p); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_idle: got %b want 1", in_ready); end
        repeat (8) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_dropped: got %b want 0", out_valid); end
        run_op(32'h0000_0057, 8'h02, n, pv);
        total++; if (n !== 2) begin bad++; $display("FAIL post_rst_lat: got %0d want 2", n); end
        total++; if (pv !== 32'h0000_00AE) begin bad++; $display("FAIL post_rst_p: got %h want 000000ae", pv); end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_column();
        test_zero_one();
        test_back_to_back();
        test_steps();
        test_reset_mid();
        idle_cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
